// File: rtl/mxint_pkg.sv
// Shared definitions for the MXINT block encoder: default geometry,
// encoder state encoding and a width helper for counters/positions.
package mxint_pkg;

  localparam int BLK_DEF   = 8;
  localparam int IN_W_DEF  = 16;
  localparam int MAN_W_DEF = 8;
  localparam int SE_W_DEF  = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_EXP  = 2'd2,
    ST_EMIT = 2'd3
  } enc_state_t;

  // Bits needed to index n items; never less than one bit.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < n) r = r + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/mxint_lod.sv
// Combinational leading-one detector: reports the index of the most
// significant set bit of VEC, and ZERO when no bit is set (POS is 0 then).
module mxint_lod
  import mxint_pkg::*;
#(
  parameter int W     = 17,
  parameter int POS_W = clog2_min1(W)
) (
  input  logic [W-1:0]     VEC,
  output logic [POS_W-1:0] POS,
  output logic             ZERO
);

  // Scan upward so the highest set bit wins.
  always_comb begin
    POS = '0;
    for (int i = 0; i < W; i++) begin
      if (VEC[i]) POS = POS_W'(i);
    end
  end

  assign ZERO = (VEC == '0);

endmodule

// File: rtl/mxint_block_encoder.sv
// MXINT block encoder: collects BLK signed fixed-point samples, finds one
// shared shift per block from the OR of the sample magnitudes, then emits
// MAN_W-bit mantissas together with that shift.
// Optional build macro MXENC_ROUND_EN: round-half-up with saturation
// instead of plain truncation toward -inf.
module mxint_block_encoder
  import mxint_pkg::*;
#(
  parameter int BLK   = BLK_DEF,
  parameter int IN_W  = IN_W_DEF,
  parameter int MAN_W = MAN_W_DEF,
  parameter int SE_W  = SE_W_DEF
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [IN_W-1:0]  IN_DATA,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [MAN_W-1:0] OUT_MAN,
  output logic [SE_W-1:0]  OUT_SE,
  output logic             OUT_LAST
);

  localparam int CW      = clog2_min1(BLK);
  localparam int MW      = IN_W + 1;
  localparam int PW      = clog2_min1(MW);
  localparam int SE_MAX  = (1 << SE_W) - 1;
  localparam int MAN_MAX = (1 << (MAN_W - 1)) - 1;
  localparam int MAN_MIN = -(1 << (MAN_W - 1));

  enc_state_t              state_reg, state_next;
  logic [CW-1:0]           cnt_reg;
  logic [IN_W:0]           mag_or_reg;
  logic [SE_W-1:0]         se_reg;
  logic [MAN_W-1:0]        out_man_reg;
  logic                    out_valid_reg;
  logic                    out_last_reg;
  logic signed [IN_W-1:0]  blk_mem [BLK];

  logic                    in_fire, out_fire, last_cnt;
  logic signed [IN_W:0]    in_ext;
  logic [IN_W:0]           in_mag;
  logic [PW-1:0]           lod_pos;
  logic                    lod_zero;
  int                      shift_amt;
  logic [SE_W-1:0]         se_new;

  assign in_fire  = IN_VALID && (state_reg == ST_FILL);
  assign out_fire = out_valid_reg && OUT_READY;
  assign last_cnt = (cnt_reg == CW'(BLK - 1));

  // One extra bit so the most negative sample has a representable magnitude.
  assign in_ext = {IN_DATA[IN_W-1], IN_DATA};
  assign in_mag = in_ext[IN_W] ? $unsigned(-in_ext) : $unsigned(in_ext);

  mxint_lod #(.W(MW), .POS_W(PW)) u_lod (
    .VEC  (mag_or_reg),
    .POS  (lod_pos),
    .ZERO (lod_zero)
  );

  // Shared shift: keep the leading one just below the mantissa sign bit.
  always_comb begin
    shift_amt = 0;
    if (!lod_zero && (int'(lod_pos) > MAN_W - 2)) shift_amt = int'(lod_pos) - (MAN_W - 2);
    if (shift_amt > SE_MAX) shift_amt = SE_MAX;
  end
  assign se_new = SE_W'(shift_amt);

  // Sample to mantissa conversion for a given shared shift.
  function automatic logic [MAN_W-1:0] encode(input logic signed [IN_W-1:0] v,
                                              input logic [SE_W-1:0] sh);
`ifdef MXENC_ROUND_EN
    logic signed [IN_W+1:0] wide;
    if (sh == '0) return v[MAN_W-1:0];
    wide = (IN_W+2)'(v);
    wide = (wide + ((IN_W+2)'(1) <<< (sh - 1'b1))) >>> sh;
    if (wide > (IN_W+2)'(MAN_MAX)) return MAN_W'(MAN_MAX);
    if (wide < (IN_W+2)'(MAN_MIN)) return MAN_W'(MAN_MIN);
    return wide[MAN_W-1:0];
`else
    logic signed [IN_W-1:0] t;
    t = v >>> sh;
    return t[MAN_W-1:0];
`endif
  endfunction

  // State register.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  // Next-state decode: fill, one cycle to pick the shift, then emit.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: state_next = ST_FILL;
      ST_FILL: if (in_fire && last_cnt) state_next = ST_EXP;
      ST_EXP:  state_next = ST_EMIT;
      ST_EMIT: if (out_fire && last_cnt) state_next = ST_FILL;
      default: state_next = ST_IDLE;
    endcase
  end

  // Block buffer write; contents need no reset since they are always refilled.
  always_ff @(posedge CLK) begin
    if (in_fire) blk_mem[cnt_reg] <= IN_DATA;
  end

  // Counter, magnitude accumulation and registered output stage.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      cnt_reg       <= '0;
      mag_or_reg    <= '0;
      se_reg        <= '0;
      out_man_reg   <= '0;
      out_valid_reg <= 1'b0;
      out_last_reg  <= 1'b0;
    end else begin
      case (state_reg)
        ST_FILL: begin
          if (in_fire) begin
            mag_or_reg <= mag_or_reg | in_mag;
            cnt_reg    <= last_cnt ? '0 : cnt_reg + CW'(1);
          end
        end
        ST_EXP: begin
          // Preload element 0 so the first mantissa is valid on entry to emit.
          se_reg        <= se_new;
          out_man_reg   <= encode(blk_mem[0], se_new);
          out_valid_reg <= 1'b1;
          out_last_reg  <= 1'b0;
        end
        ST_EMIT: begin
          if (out_fire) begin
            if (last_cnt) begin
              out_valid_reg <= 1'b0;
              out_last_reg  <= 1'b0;
              cnt_reg       <= '0;
              mag_or_reg    <= '0;
            end else begin
              cnt_reg      <= cnt_reg + CW'(1);
              out_man_reg  <= encode(blk_mem[cnt_reg + CW'(1)], se_reg);
              out_last_reg <= ((cnt_reg + CW'(1)) == CW'(BLK - 1));
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign IN_READY  = (state_reg == ST_FILL);
  assign OUT_VALID = out_valid_reg;
  assign OUT_MAN   = out_man_reg;
  assign OUT_SE    = se_reg;
  assign OUT_LAST  = out_last_reg;

endmodule

// File: tb/tb_mxint_block_encoder.sv
// Self-checking bench for mxint_block_encoder: directed and random blocks
// compared against an integer model of the block-floating-point encoding.
module tb_mxint_block_encoder;

  localparam int BLK   = 8;
  localparam int IN_W  = 16;
  localparam int MAN_W = 8;
  localparam int SE_W  = 5;

  typedef int blk_t [BLK];

  logic             CLK = 1'b0;
  logic             RSTN = 1'b0;
  logic             IN_VALID = 1'b0;
  logic [IN_W-1:0]  IN_DATA = '0;
  logic             OUT_READY = 1'b0;
  logic             IN_READY;
  logic             OUT_VALID;
  logic [MAN_W-1:0] OUT_MAN;
  logic [SE_W-1:0]  OUT_SE;
  logic             OUT_LAST;

  int n_checks = 0;
  int n_fail   = 0;

  mxint_block_encoder #(.BLK(BLK), .IN_W(IN_W), .MAN_W(MAN_W), .SE_W(SE_W)) dut (
    .CLK       (CLK),
    .RSTN      (RSTN),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .IN_DATA   (IN_DATA),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .OUT_MAN   (OUT_MAN),
    .OUT_SE    (OUT_SE),
    .OUT_LAST  (OUT_LAST)
  );

  always #5 CLK = ~CLK;

  // Reference: shift so the largest magnitude fits in MAN_W-1 value bits.
  function automatic int model_se(input blk_t v);
    int orv, p, s, a;
    orv = 0;
    for (int i = 0; i < BLK; i++) begin
      a = (v[i] < 0) ? -v[i] : v[i];
      orv = orv | a;
    end
    p = -1;
    for (int b = 0; b < 31; b++) if (orv[b]) p = b;
    s = p - (MAN_W - 2);
    if (s < 0) s = 0;
    if (s > (1 << SE_W) - 1) s = (1 << SE_W) - 1;
    return s;
  endfunction

  function automatic int model_man(input int x, input int s);
`ifdef MXENC_ROUND_EN
    int r;
    if (s == 0) return x;
    r = (x + (1 << (s - 1))) >>> s;
    if (r > 127) r = 127;
    if (r < -128) r = -128;
    return r;
`else
    return x >>> s;
`endif
  endfunction

  task automatic send_block(input blk_t v, input string name);
    int t;
    for (int i = 0; i < BLK; i++) begin
      IN_DATA  = IN_W'(v[i]);
      IN_VALID = 1'b1;
      t = 0;
      while (IN_READY !== 1'b1 && t < 50) begin
        @(negedge CLK);
        t++;
      end
      n_checks++;
      if (t >= 50) begin
        n_fail++;
        $display("FAIL %s in_ready_timeout: IN_READY=%b required 1 within 50 cycles", name, IN_READY);
        IN_VALID = 1'b0;
        return;
      end
      @(negedge CLK);
    end
    IN_VALID = 1'b0;
    // The shift is still being chosen right after the last accept.
    n_checks++;
    if (OUT_VALID !== 1'b0) begin
      n_fail++;
      $display("FAIL %s early_out_valid: OUT_VALID=%b required 0", name, OUT_VALID);
    end
  endtask

  task automatic recv_block(input blk_t v, input int stall_at, input string name);
    int se, em, t;
    se = model_se(v);
    OUT_READY = 1'b1;
    for (int i = 0; i < BLK; i++) begin
      t = 0;
      while (OUT_VALID !== 1'b1 && t < 50) begin
        @(negedge CLK);
        t++;
      end
      n_checks++;
      if (t >= 50) begin
        n_fail++;
        $display("FAIL %s out_valid_timeout elem %0d: OUT_VALID=%b required 1", name, i, OUT_VALID);
        return;
      end
      em = model_man(v[i], se);
      n_checks++;
      if (OUT_MAN !== MAN_W'(em)) begin
        n_fail++;
        $display("FAIL %s man[%0d]: got %0d required %0d", name, i, $signed(OUT_MAN), em);
      end
      n_checks++;
      if (OUT_SE !== SE_W'(se)) begin
        n_fail++;
        $display("FAIL %s se[%0d]: got %0d required %0d", name, i, OUT_SE, se);
      end
      n_checks++;
      if (OUT_LAST !== (i == BLK - 1)) begin
        n_fail++;
        $display("FAIL %s last[%0d]: got %b required %b", name, i, OUT_LAST, (i == BLK - 1));
      end
      if (i == stall_at) begin
        OUT_READY = 1'b0;
        for (int c = 0; c < 3; c++) begin
          @(negedge CLK);
          n_checks++;
          if (OUT_VALID !== 1'b1 || OUT_MAN !== MAN_W'(em) || OUT_SE !== SE_W'(se) || IN_READY !== 1'b0) begin
            n_fail++;
            $display("FAIL %s stall_hold cyc %0d: valid=%b man=%0d se=%0d in_ready=%b required 1/%0d/%0d/0",
                     name, c, OUT_VALID, $signed(OUT_MAN), OUT_SE, IN_READY, em, se);
          end
        end
        OUT_READY = 1'b1;
      end
      @(negedge CLK);
    end
    n_checks++;
    if (OUT_VALID !== 1'b0 || IN_READY !== 1'b1) begin
      n_fail++;
      $display("FAIL %s block_end: OUT_VALID=%b IN_READY=%b required 0/1", name, OUT_VALID, IN_READY);
    end
    OUT_READY = 1'b0;
    $display("block %s: se=%0d man0=%0d stall_at=%0d", name, se, model_man(v[0], se), stall_at);
  endtask

  task automatic check_all_zero(input string name);
    n_checks++;
    if (IN_READY !== 1'b0 || OUT_VALID !== 1'b0 || OUT_MAN !== '0 || OUT_SE !== '0 || OUT_LAST !== 1'b0) begin
      n_fail++;
      $display("FAIL %s reset_outputs: ready=%b valid=%b man=%0d se=%0d last=%b required all 0",
               name, IN_READY, OUT_VALID, OUT_MAN, OUT_SE, OUT_LAST);
    end
  endtask

  task automatic release_reset(input string name);
    @(negedge CLK);
    RSTN = 1'b1;
    #1;
    n_checks++;
    if (IN_READY !== 1'b0) begin
      n_fail++;
      $display("FAIL %s idle_cycle: IN_READY=%b required 0", name, IN_READY);
    end
    @(negedge CLK);
    n_checks++;
    if (IN_READY !== 1'b1) begin
      n_fail++;
      $display("FAIL %s fill_entry: IN_READY=%b required 1", name, IN_READY);
    end
  endtask

  function automatic blk_t rand_block();
    blk_t v;
    int sh;
    sh = 16 + $urandom_range(0, 15);
    for (int i = 0; i < BLK; i++) begin
      case ($urandom_range(0, 11))
        0:       v[i] = -32768;
        1:       v[i] = 32767;
        default: v[i] = int'($urandom) >>> sh;
      endcase
    end
    return v;
  endfunction

  task automatic test_reset();
    RSTN = 1'b0;
    #12;
    check_all_zero("reset");
    release_reset("reset");
  endtask

  task automatic test_directed();
    blk_t z, a, b, c, d;
    z = '{0, 0, 0, 0, 0, 0, 0, 0};
    a = '{100, -3, 5, 0, 0, 0, 0, 0};
    b = '{32767, 256, -32768, 1, -1, 0, 0, 0};
    c = '{383, 0, 0, 0, 0, 0, 0, 0};
    d = '{32767, 0, 0, 0, 0, 0, 0, 0};
    send_block(z, "zeros");     recv_block(z, -1, "zeros");
    send_block(a, "small");     recv_block(a, -1, "small");
    send_block(b, "extremes");  recv_block(b, -1, "extremes");
    send_block(c, "round383");  recv_block(c, -1, "round383");
    send_block(d, "sat32767");  recv_block(d, -1, "sat32767");
  endtask

  task automatic test_backpressure();
    blk_t v;
    v = '{-1200, 4000, 77, -9, 31000, -31000, 2, 0};
    send_block(v, "stall2");
    recv_block(v, 2, "stall2");
  endtask

  task automatic test_random();
    blk_t v;
    for (int k = 0; k < 10; k++) begin
      v = rand_block();
      send_block(v, $sformatf("rand%0d", k));
      recv_block(v, ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, BLK - 1)) : -1,
                 $sformatf("rand%0d", k));
    end
  endtask

  task automatic test_reset_mid();
    blk_t v, w;
    int t;
    v = '{1000, 2000, 3000, 4000, -5000, 6000, 7000, 8000};
    w = '{-7, 64, -64, 63, 12, -128, 5, 1};
    send_block(v, "mid_a");
    OUT_READY = 1'b1;
    t = 0;
    while (OUT_VALID !== 1'b1 && t < 50) begin
      @(negedge CLK);
      t++;
    end
    repeat (3) @(negedge CLK);
    OUT_READY = 1'b0;
    #2;
    RSTN = 1'b0;
    #1;
    check_all_zero("mid_emit");
    release_reset("mid_emit");
    send_block(w, "fresh_a");
    recv_block(w, -1, "fresh_a");
    // Partial fill interrupted by reset must not leak into the next block.
    IN_VALID = 1'b1;
    for (int i = 0; i < 5; i++) begin
      IN_DATA = IN_W'(30000 - i);
      @(negedge CLK);
    end
    IN_VALID = 1'b0;
    #2;
    RSTN = 1'b0;
    #1;
    check_all_zero("mid_fill");
    release_reset("mid_fill");
    send_block(w, "fresh_b");
    recv_block(w, -1, "fresh_b");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
